kbd_ps2_rx: RTL and testbench

- Keyboard receiver that feeds the PPI's port A and raises IRQ1.
- Deserialises 11-bit PS/2 frames from the keyboard connector and holds the 8-bit scan code until software pulses the keyboard-clear bit (PPI port B bit 7).
- Inhibits the keyboard by pulling its clock low while a code is pending or while port B bit 6 is low.

---
 rtl/kbd_ps2_rx_pkg.sv | 20 ++
 rtl/kbd_ps2_rx_if.sv | 21 ++
 rtl/kbd_ps2_rx_sync_edge.sv | 39 +++
 rtl/kbd_ps2_rx.sv | 171 +++++++++++++++++
 tb/tb_kbd_ps2_rx.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/kbd_ps2_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package kbd_pkg;

    localparam int unsigned PS2_FRAME_BITS     = 11;
    localparam int unsigned PS2_DATA_BITS      = 8;
    localparam int unsigned KBD_TIMEOUT_CYCLES = 2000;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Data plus parity must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/kbd_ps2_rx_if.sv
// PPI-side bundle of the keyboard receiver: port B control bits in, port A code and status out.
interface kbd_ps2_rx_if;
    import kbd_pkg::*;

    logic                     kbd_clk_en;
    logic                     kbd_clr;
    logic [PS2_DATA_BITS-1:0] scan_code;
    logic                     irq1;
    logic                     frame_err;
    logic                     overrun;

    modport master (
        output kbd_clk_en, kbd_clr,
        input  scan_code, irq1, frame_err, overrun
    );

    modport slave (
        input  kbd_clk_en, kbd_clr,
        output scan_code, irq1, frame_err, overrun
    );
endinterface

// File: rtl/kbd_ps2_rx_sync_edge.sv
// Synchroniser for the PS/2 pins plus a registered falling-edge strobe on ps2_clk.
module ps2_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic data_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic                   fall_q;
    logic                   data_q;

    // Data is captured alongside the strobe so both reach the FSM in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            fall_q      <= 1'b0;
            data_q      <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
            fall_q      <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
            data_q      <= data_sync_q[SYNC_STAGES-1];
        end
    end

    assign data_o = data_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/kbd_ps2_rx.sv
// PS/2 keyboard receiver feeding PPI port A and IRQ1.
// Build option KBD_FIFO_EN replaces the single holding register with a FIFO_DEPTH-entry FIFO.
module kbd_ps2_rx
    import kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = KBD_TIMEOUT_CYCLES,
    parameter int unsigned SYNC_STAGES    = 2
`ifdef KBD_FIFO_EN
    ,
    parameter int unsigned FIFO_DEPTH     = 4
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    output logic          ps2_clk_inhibit,
    kbd_ps2_rx_if.slave   ppi
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic                     bit_s, fall_s;
    rx_state_e                state_q, state_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic                     par_q, par_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic                     commit, err_d, err_q;
    logic [PS2_DATA_BITS-1:0] scan_q, scan_d;
    logic                     irq_q, irq_d, ovr_q, ovr_d, inh_q, inh_d;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .data_o     (bit_s),
        .fall_o     (fall_s)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        commit    = 1'b0;
        err_d     = 1'b0;
        if (state_q != IDLE)
            tmo_d = fall_s ? '0 : tmo_q + TW'(1);
        if (fall_s) begin
            unique case (state_q)
                IDLE: if (!bit_s) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    shift_d   = {bit_s, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = bit_s;
                    state_d = STOP;
                end
                STOP: begin
                    if (bit_s && odd_parity_ok(shift_q, par_q)) commit = 1'b1;
                    else                                        err_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            scan_q    <= '0;
            irq_q     <= 1'b0;
            ovr_q     <= 1'b0;
            inh_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            scan_q    <= scan_d;
            irq_q     <= irq_d;
            ovr_q     <= ovr_d;
            inh_q     <= inh_d;
        end
    end

`ifdef KBD_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [PS2_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]            rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]              cnt_q, cnt_d, remain;
    logic                     clr_prev_q, full, push, pop;
    logic [PS2_DATA_BITS-1:0] head;

    // Head is taken from next-state pointers so a push into an empty FIFO shows with no extra cycle.
    always_comb begin
        full   = (cnt_q == (AW+1)'(FIFO_DEPTH));
        pop    = ppi.kbd_clr & ~clr_prev_q & (cnt_q != '0);
        push   = commit & (~full | pop);
        ovr_d  = commit & full & ~pop;
        cnt_d  = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        rd_d   = rd_q + {{(AW-1){1'b0}}, pop};
        wr_d   = wr_q + {{(AW-1){1'b0}}, push};
        remain = cnt_q - {{AW{1'b0}}, pop};
        head   = (remain == '0) ? shift_q : mem_q[rd_d];
        irq_d  = ~ppi.kbd_clr & (cnt_d != '0);
        scan_d = irq_d ? head : '0;
        inh_d  = full | ~ppi.kbd_clk_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            clr_prev_q <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            clr_prev_q <= ppi.kbd_clr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= shift_q;
    end
`else
    always_comb begin
        scan_d = scan_q;
        irq_d  = irq_q;
        ovr_d  = commit & (irq_q | ppi.kbd_clr);
        inh_d  = irq_q | ~ppi.kbd_clk_en;
        if (ppi.kbd_clr) begin
            scan_d = '0;
            irq_d  = 1'b0;
        end else if (commit && !irq_q) begin
            scan_d = shift_q;
            irq_d  = 1'b1;
        end
    end
`endif

    assign ps2_clk_inhibit = inh_q;
    assign ppi.scan_code   = scan_q;
    assign ppi.irq1        = irq_q;
    assign ppi.frame_err   = err_q;
    assign ppi.overrun     = ovr_q;

endmodule

// File: tb/tb_kbd_ps2_rx.sv
// Directed bench for kbd_ps2_rx; with KBD_FIFO_EN defined it exercises the FIFO build instead.
module tb_kbd_ps2_rx;
    import kbd_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic ps2_clk_inhibit;

    kbd_ps2_rx_if ppi_if ();

    kbd_ps2_rx dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ps2_clk         (ps2_clk),
        .ps2_data        (ps2_data),
        .ps2_clk_inhibit (ps2_clk_inhibit),
        .ppi             (ppi_if)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned err_cnt = 0;
    int unsigned ovr_cnt = 0;
    int unsigned lat_irq, lat_inh, e0, o0;

    always @(negedge clk) begin
        if (ppi_if.frame_err) err_cnt++;
        if (ppi_if.overrun)   ovr_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends the first nbits of a frame; latency of irq1/inhibit is measured from the stop-bit fall.
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                              input int unsigned nbits);
        logic [PS2_FRAME_BITS-1:0] fr;
        fr = {stop, (~^d) ^ par_flip, d, 1'b0};
        lat_irq = 0;
        lat_inh = 0;
        for (int unsigned i = 0; i < nbits; i++) begin
            @(posedge clk); #1 ps2_data = fr[i];
            repeat (10) @(posedge clk);
            #1 ps2_clk = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                @(posedge clk); #1;
                if (lat_irq == 0 && ppi_if.irq1)      lat_irq = c;
                if (lat_inh == 0 && ps2_clk_inhibit)  lat_inh = c;
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (15) @(posedge clk);
        #1;
    endtask

    task automatic clear_code(input int unsigned n);
        @(posedge clk); #1 ppi_if.kbd_clr = 1'b1;
        repeat (n) @(posedge clk);
        #1 ppi_if.kbd_clr = 1'b0;
        @(posedge clk); #1;
    endtask

`ifdef KBD_FIFO_EN
    logic [7:0] exp_seq [3] = '{8'h32, 8'h21, 8'h00};
`endif

    initial begin
        ppi_if.kbd_clk_en = 1'b1;
        ppi_if.kbd_clr    = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_scan", ppi_if.scan_code, 8'h00);
        check_eq("rst_irq1", ppi_if.irq1, 1'b0);
        check_eq("rst_inh",  ps2_clk_inhibit, 1'b0);
        check_eq("rst_err",  ppi_if.frame_err, 1'b0);
        check_eq("rst_ovr",  ppi_if.overrun, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

`ifdef KBD_FIFO_EN
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        check_eq("fifo_lat_irq", lat_irq, 4);
        send_frame(8'h32, 1'b0, 1'b1, 11);
        send_frame(8'h21, 1'b0, 1'b1, 11);
        check_eq("fifo_head0", ppi_if.scan_code, 8'h1C);
        check_eq("fifo_irq0",  ppi_if.irq1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 ppi_if.kbd_clr = 1'b1;
            @(posedge clk); #1;
            check_eq("fifo_clr_irq",  ppi_if.irq1, 1'b0);
            check_eq("fifo_clr_scan", ppi_if.scan_code, 8'h00);
            @(posedge clk); #1 ppi_if.kbd_clr = 1'b0;
            @(posedge clk); #1;
            check_eq("fifo_pop_scan", ppi_if.scan_code, exp_seq[k]);
            check_eq("fifo_pop_irq",  ppi_if.irq1, (k < 2) ? 1'b1 : 1'b0);
        end
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b1, 11);
        send_frame(8'h22, 1'b0, 1'b1, 11);
        send_frame(8'h33, 1'b0, 1'b1, 11);
        send_frame(8'h44, 1'b0, 1'b1, 11);
        check_eq("fifo_full_noovr", ovr_cnt - o0, 0);
        check_eq("fifo_full_inh",   ps2_clk_inhibit, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1, 11);
        check_eq("fifo_ovr",       ovr_cnt - o0, 1);
        check_eq("fifo_ovr_head",  ppi_if.scan_code, 8'h11);
`else
        // Valid frame and output latency
        e0 = err_cnt; o0 = ovr_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        check_eq("valid_lat_irq", lat_irq, 4);
        check_eq("valid_lat_inh", lat_inh, 5);
        check_eq("valid_scan",    ppi_if.scan_code, 8'h1C);
        check_eq("valid_err",     err_cnt - e0, 0);
        clear_code(2);
        check_eq("clr_scan", ppi_if.scan_code, 8'h00);
        check_eq("clr_irq1", ppi_if.irq1, 1'b0);
        check_eq("clr_inh",  ps2_clk_inhibit, 1'b0);

        // Parity and stop-bit errors
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        check_eq("par_err",  err_cnt - e0, 1);
        check_eq("par_irq1", ppi_if.irq1, 1'b0);
        check_eq("par_scan", ppi_if.scan_code, 8'h00);
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        check_eq("stop_err",  err_cnt - e0, 2);
        check_eq("stop_irq1", ppi_if.irq1, 1'b0);

        // Timeout after start + 3 data bits
        send_frame(8'h00, 1'b0, 1'b1, 4);
        repeat (1800) @(posedge clk);
        #1 check_eq("tmo_early", err_cnt - e0, 2);
        repeat (300) @(posedge clk);
        #1 check_eq("tmo_err", err_cnt - e0, 3);
        send_frame(8'h2A, 1'b0, 1'b1, 11);
        check_eq("tmo_next_scan", ppi_if.scan_code, 8'h2A);
        check_eq("tmo_next_irq1", ppi_if.irq1, 1'b1);
        clear_code(2);

        // Overrun while pending, then clear
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        send_frame(8'h9C, 1'b0, 1'b1, 11);
        check_eq("ovr_pulse", ovr_cnt - o0, 1);
        check_eq("ovr_scan",  ppi_if.scan_code, 8'h1C);
        clear_code(2);
        check_eq("ovr_clr_scan", ppi_if.scan_code, 8'h00);
        check_eq("ovr_clr_irq1", ppi_if.irq1, 1'b0);
        check_eq("ovr_clr_inh",  ps2_clk_inhibit, 1'b0);

        // Commit while clear is held: clear wins
        @(posedge clk); #1 ppi_if.kbd_clr = 1'b1;
        send_frame(8'h3B, 1'b0, 1'b1, 11);
        check_eq("clrwin_ovr",  ovr_cnt - o0, 2);
        check_eq("clrwin_irq1", ppi_if.irq1, 1'b0);
        ppi_if.kbd_clr = 1'b0;

        // Inhibit from kbd_clk_en
        @(posedge clk); #1 ppi_if.kbd_clk_en = 1'b0;
        @(posedge clk); #1;
        check_eq("inh_en", ps2_clk_inhibit, 1'b1);
        ppi_if.kbd_clk_en = 1'b1;
        @(posedge clk); #1;
        check_eq("inh_en_off", ps2_clk_inhibit, 1'b0);

        // Reset mid-frame with a code pending
        send_frame(8'h2A, 1'b0, 1'b1, 11);
        check_eq("pre_rst_inh", ps2_clk_inhibit, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1, 5);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("midrst_scan", ppi_if.scan_code, 8'h00);
        check_eq("midrst_irq1", ppi_if.irq1, 1'b0);
        check_eq("midrst_inh",  ps2_clk_inhibit, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        check_eq("postrst_scan", ppi_if.scan_code, 8'h1C);
        check_eq("postrst_irq1", ppi_if.irq1, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
